// File: rtl/md_pkg.sv
// md_pkg: op encodings, default latencies and FSM states
// shared by the multiply/divide unit and its divider core.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int MD_WIDTH_DEF    = 32;
    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic int md_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/md_if.sv
// md_if: E-stage request / HI-LO result bundle for md_unit.
// master = E stage, slave = md_unit.
interface md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_div_core.sv
// md_div_core: combinational signed/unsigned divide with
// MIPS-style divide-by-zero and overflow results.
module md_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;

    always_comb begin
        neg_a = is_signed & a[WIDTH-1];
        neg_b = is_signed & b[WIDTH-1];
        mag_a = neg_a ? (~a + 1'b1) : a;
        mag_b = neg_b ? (~b + 1'b1) : b;
        uq    = '0;
        ur    = '0;
        if (mag_b != '0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        // quotient truncates toward zero, remainder follows dividend
        q = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
        r = neg_a ? (~ur + 1'b1) : ur;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (is_signed && a == MIN && b == '1) begin
            q = MIN;
            r = '0;
        end
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/DIV unit with HI/LO registers.
// Divider is compiled in only when MDU_DIV_EN is defined.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = MD_WIDTH_DEF,
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);

`ifdef MDU_DIV_EN
    localparam int CNT_MAX = md_max(MULT_LAT, DIV_LAT);
`else
    localparam int CNT_MAX = MULT_LAT;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_L = CW'(MULT_LAT);

    if (MULT_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
        $error("md_unit: latencies must be >= 1");
    end

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic is_mul;
    logic is_div;
    logic is_mth;
    logic is_mtl;
    logic is_signed;
    logic accept;
    logic commit;
    logic mt_hi;
    logic mt_lo;

    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        is_mth = 1'b0;
        is_mtl = 1'b0;
        unique case (1'b1)
            (md.op == MD_MULT),
            (md.op == MD_MULTU): is_mul = 1'b1;
`ifdef MDU_DIV_EN
            (md.op == MD_DIV),
            (md.op == MD_DIVU):  is_div = 1'b1;
`endif
            (md.op == MD_MTHI):  is_mth = 1'b1;
            (md.op == MD_MTLO):  is_mtl = 1'b1;
            default: ;
        endcase
    end

    // signed ops are the even encodings (MULT, DIV)
    assign is_signed = ~md.op[0];

    // sign/zero-extend to 2*WIDTH so one multiplier serves both
    assign ext_a = {{WIDTH{is_signed & md.a[WIDTH-1]}}, md.a};
    assign ext_b = {{WIDTH{is_signed & md.b[WIDTH-1]}}, md.b};
    assign prod  = ext_a * ext_b;

`ifdef MDU_DIV_EN
    localparam logic [CW-1:0] DIV_L = CW'(DIV_LAT);

    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    md_div_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .a        (md.a),
        .b        (md.b),
        .is_signed(is_signed),
        .q        (div_q),
        .r        (div_r)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end
            if (commit) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
            if (mt_hi) hi_q <= md.a;
            if (mt_lo) lo_q <= md.a;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (md.start && (is_mul || is_div)) begin
                    accept  = 1'b1;
                    state_d = MD_RUN;
                    cnt_d   = MUL_L;
`ifdef MDU_DIV_EN
                    if (is_div) cnt_d = DIV_L;
`endif
                end
            end
            MD_RUN: begin
                if (cnt_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        md.busy = (state_q == MD_RUN);
        mt_hi   = (state_q == MD_IDLE) && md.start && is_mth;
        mt_lo   = (state_q == MD_IDLE) && md.start && is_mtl;
        res_hi  = prod[2*WIDTH-1:WIDTH];
        res_lo  = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div) begin
            res_hi = div_r;
            res_lo = div_q;
        end
`endif
    end

    assign md.hi = hi_q;
    assign md.lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors for md_unit (MULT/LAT 5, DIV/LAT 10).
// Divider vectors run when MDU_DIV_EN is defined.
module tb_md_unit;
    import md_pkg::*;

    localparam int MLAT = 5;
    localparam int DLAT = 10;

    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_if #(.WIDTH(32)) bus ();

    md_unit #(
        .WIDTH   (32),
        .MULT_LAT(MLAT),
        .DIV_LAT (DLAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_md(input string tag, input logic [2:0] o,
                          input logic [31:0] xa, input logic [31:0] xb,
                          input int lat,
                          input logic [31:0] eh, input logic [31:0] el);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = xa;
        bus.b     = xb;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < lat; i++) begin
            chk({tag, ".busy"}, {31'b0, bus.busy}, 32'd1);
            if (i == 0) begin
                chk({tag, ".hi_hold"}, bus.hi, m_hi);
                chk({tag, ".lo_hold"}, bus.lo, m_lo);
            end
            step();
        end
        chk({tag, ".idle"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, ".hi"}, bus.hi, eh);
        chk({tag, ".lo"}, bus.lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic mt(input string tag, input logic [2:0] o,
                      input logic [31:0] xa);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = xa;
        step();
        bus.start = 1'b0;
        if (o == MD_MTHI) m_hi = xa;
        if (o == MD_MTLO) m_lo = xa;
        chk({tag, ".busy"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, ".hi"}, bus.hi, m_hi);
        chk({tag, ".lo"}, bus.lo, m_lo);
    endtask

    initial begin
        n_run     = 0;
        n_fail    = 0;
        m_hi      = '0;
        m_lo      = '0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd7;
        bus.a     = '0;
        bus.b     = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst.busy", {31'b0, bus.busy}, 32'd0);
        chk("rst.hi", bus.hi, 32'd0);
        chk("rst.lo", bus.lo, 32'd0);

        run_md("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, MLAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, MLAT,
               32'h0000_0001, 32'hFFFF_FFFE);
        run_md("mult_neg2", MD_MULT, 32'h8000_0000, 32'h8000_0000,
               MLAT, 32'h4000_0000, 32'h0000_0000);

        // MTLO while busy must be dropped
        bus.start = 1'b1;
        bus.op    = MD_MULT;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        step();
        bus.op = MD_MTLO;
        bus.a  = 32'h1234;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < MLAT - 1; i++) begin
            chk("mtlo_busy.busy", {31'b0, bus.busy}, 32'd1);
            step();
        end
        chk("mtlo_busy.idle", {31'b0, bus.busy}, 32'd0);
        chk("mtlo_busy.hi", bus.hi, 32'd0);
        chk("mtlo_busy.lo", bus.lo, 32'd6);
        m_hi = 32'd0;
        m_lo = 32'd6;

        mt("mthi", MD_MTHI, 32'h0000_ABCD);
        mt("mtlo", MD_MTLO, 32'h0000_5555);
        mt("nop6", 3'd6, 32'hDEAD_BEEF);
        mt("nop7", 3'd7, 32'hDEAD_BEEF);

`ifdef MDU_DIV_EN
        run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, DLAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div0", MD_DIV, 32'd5, 32'd0, DLAT,
               32'd5, 32'hFFFF_FFFF);
        run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DLAT,
               32'd0, 32'h8000_0000);
        run_md("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, DLAT,
               32'd1, 32'h7FFF_FFFC);
        run_md("div_pos_neg", MD_DIV, 32'd7, 32'hFFFF_FFFE, DLAT,
               32'd1, 32'hFFFF_FFFD);
`else
        bus.start = 1'b1;
        bus.op    = MD_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < DLAT + 2; i++) begin
            chk("divu_off.busy", {31'b0, bus.busy}, 32'd0);
            step();
        end
        chk("divu_off.hi", bus.hi, m_hi);
        chk("divu_off.lo", bus.lo, m_lo);
`endif

        // reset lands in the third busy cycle of a MULT
        bus.start = 1'b1;
        bus.op    = MD_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        step();
        bus.start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid.busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_mid.hi", bus.hi, 32'd0);
        chk("rst_mid.lo", bus.lo, 32'd0);
        for (int i = 0; i < MLAT + 1; i++) step();
        chk("rst_late.busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_late.hi", bus.hi, 32'd0);
        chk("rst_late.lo", bus.lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
